truth_scan_ctrl: RTL

Sequencing controller for the team's 3-input combinational function blocks. On a start request it drives all eight input combinations onto a 3-bit bus in order. After a programmable settle time it samples the 1-bit function output for each combination and assembles the measured 8-entry truth map. It then reports the map, a pass/fail against an expected map, and a mismatch count. It sits between a control/stimulus source and any 3-input function block, and serves as the self-check sequencer for that family of circuits.

---
 rtl/truth_scan_pkg.sv | 16 +
 rtl/truth_scan_ctrl_popcount8.sv | 14 +
 rtl/truth_scan_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/truth_scan_pkg.sv
// Shared types and constants for the 3-input truth-map scan controller.
package truth_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

    localparam int N_VECTORS = 8;

    // Reference 3-input comparator: 1 for {A,B,C} = 000, 001, 101, 110.
    localparam logic [7:0] CMP3_MAP = 8'h63;

endpackage

// File: rtl/truth_scan_ctrl_popcount8.sv
// Combinational population count of an 8-bit word; the 4-bit result covers 0..8.
module popcount8 (
    input  logic [7:0] data,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, data[i]};
        end
    end

endmodule

// File: rtl/truth_scan_ctrl.sv
// Drives all eight {A,B,C} combinations onto an external 3-input block, samples its
// output after a settle time and reports the measured map against an expected map.
module truth_scan_ctrl
    import truth_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  expected,
    input  logic        s_i,
    output logic [2:0]  abc_o,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result,
    output logic        pass,
    output logic [3:0]  mismatch_cnt,
    output scan_state_e state_dbg
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX    = 3'(N_VECTORS - 1);

    scan_state_e state;
    logic [2:0]  idx;
    logic [3:0]  settle_cnt;
    logic [7:0]  exp_latched;
    logic [7:0]  sampled_map;
    logic [3:0]  final_cnt;

    // The map as it will look once the current SAMPLE cycle has captured s_i; the
    // final verdict is computed from it so pass/mismatch_cnt are valid with done.
    always_comb begin
        sampled_map      = result;
        sampled_map[idx] = s_i;
    end

    popcount8 u_popcount (
        .data  (sampled_map ^ exp_latched),
        .count (final_cnt)
    );

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            settle_cnt   <= 4'd0;
            exp_latched  <= 8'h00;
            abc_o        <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 8'h00;
            pass         <= 1'b0;
            mismatch_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_latched  <= expected;
                        result       <= 8'h00;
                        pass         <= 1'b0;
                        mismatch_cnt <= 4'd0;
                        idx          <= 3'd0;
                        settle_cnt   <= 4'd0;
                        abc_o        <= 3'd0;
                        busy         <= 1'b1;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    result <= sampled_map;
                    if (idx == LAST_IDX) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        pass         <= (sampled_map == exp_latched);
                        mismatch_cnt <= final_cnt;
                        state        <= DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        abc_o <= idx + 3'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
